// File: rtl/cpu_pkg.sv
// Package: cpu_pkg
// Purpose: shared definitions for the hiddenCPU sequencer slice.
//   - ALU opcode constants and the LDI mode encoding
//   - instruction field bit positions
//   - sequencer state encoding
//   - decode helper that recognises the two-byte LDI instruction
package cpu_pkg;

  // ALU opcodes carried in instruction bits [7:6]
  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_XOR = 2'd2;
  localparam logic [1:0] OP_MOV = 2'd3;

  // Mode value that turns OP_MOV into a load-immediate
  localparam logic [1:0] MODE_LDI = 2'b11;

  // Instruction field bit positions
  localparam int OPC_HI  = 7;
  localparam int OPC_LO  = 6;
  localparam int RD_HI   = 5;
  localparam int RD_LO   = 4;
  localparam int RS_HI   = 3;
  localparam int RS_LO   = 2;
  localparam int MODE_HI = 1;
  localparam int MODE_LO = 0;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_FETCH_IMM = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_WRITEBACK = 3'd4
  } state_t;

  // True when the instruction byte is LDI (a second, immediate byte follows)
  function automatic logic is_ldi(input logic [7:0] instr);
    return (instr[OPC_HI:OPC_LO] == OP_MOV) && (instr[MODE_HI:MODE_LO] == MODE_LDI);
  endfunction

endpackage

// File: rtl/regfile_4x8.sv
// Module: regfile_4x8
// Purpose: four 8-bit architectural registers.
// Ports:
//   clk, rst      - clock, synchronous active-high reset (all entries -> REG_RST)
//   ra0, ra1      - read addresses; rd0, rd1 are combinational read data
//   we, wa, wd    - synchronous write enable / address / data
module regfile_4x8 #(
  parameter logic [7:0] REG_RST = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] ra0,
  input  logic [1:0] ra1,
  output logic [7:0] rd0,
  output logic [7:0] rd1,
  input  logic       we,
  input  logic [1:0] wa,
  input  logic [7:0] wd
);

  logic [7:0] regs_r [4];

  // Register storage: reset all entries, otherwise single write port
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        regs_r[i] <= REG_RST;
      end
    end else if (we) begin
      regs_r[wa] <= wd;
    end
  end

  assign rd0 = regs_r[ra0];
  assign rd1 = regs_r[ra1];

endmodule

// File: rtl/cpu_sequencer.sv
// Module: cpu_sequencer
// Purpose: fetch / decode / writeback control stage of the hiddenCPU. Fetches
//   instruction bytes over a valid/ready interface, owns the register file and
//   the program counter, drives the external ALU from registered operands and
//   commits the registered ALU result, flags, branches and toggle.
// Ports:
//   clk, rst                    - clock, synchronous active-high reset
//   instr_in/instr_valid/instr_ready - instruction byte handshake
//   pc                          - address of the next byte to fetch
//   alu_opcode/alu_addrs/alu_d0/alu_d1 - ALU drive (held stable between uses)
//   alu_dout/alu_carry/alu_borrow      - ALU result and arithmetic flags
//   alu_bcf/alu_bbf/alu_buc/alu_toggle - ALU branch and toggle requests
//   carry_flag/borrow_flag      - architectural flags
//   toggle_out                  - toggle flip-flop
//   busy                        - high whenever the sequencer is not in FETCH
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int         PC_W    = 8,
  parameter logic [7:0] REG_RST = 8'h00
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [7:0]      instr_in,
  input  logic            instr_valid,
  output logic            instr_ready,
  output logic [PC_W-1:0] pc,
  output logic [1:0]      alu_opcode,
  output logic [3:0]      alu_addrs,
  output logic [7:0]      alu_d0,
  output logic [7:0]      alu_d1,
  input  logic [7:0]      alu_dout,
  input  logic            alu_carry,
  input  logic            alu_borrow,
  input  logic            alu_bcf,
  input  logic            alu_bbf,
  input  logic            alu_buc,
  input  logic            alu_toggle,
  output logic            carry_flag,
  output logic            borrow_flag,
  output logic            toggle_out,
  output logic            busy
);

  state_t state_r;
  state_t state_next_s;

  logic [PC_W-1:0] pc_r;
  logic [7:0]      instr_r;
  logic [7:0]      imm_r;
  logic [7:0]      op0_r;
  logic [7:0]      op1_r;
  logic [7:0]      res_r;
  logic            alu_carry_r;
  logic            alu_borrow_r;
  logic            bcf_r;
  logic            bbf_r;
  logic            buc_r;
  logic            tog_r;
  logic            carry_flag_r;
  logic            borrow_flag_r;
  logic            toggle_r;

  logic            ready_s;
  logic            busy_s;
  logic            rf_we_s;
  logic            hs_s;
  logic            take_s;
  logic [7:0]      rf_rd0_s;
  logic [7:0]      rf_rd1_s;
  logic [PC_W-1:0] pc_one_s;
  logic [PC_W-1:0] pc_target_s;
  logic [PC_W+7:0] res_ext_s;

  assign pc_one_s = {{(PC_W-1){1'b0}}, 1'b1};

  // Branch target is the low PC_W bits of the zero-extended result
  assign res_ext_s   = {{PC_W{1'b0}}, res_r};
  assign pc_target_s = res_ext_s[PC_W-1:0];

  // Flags are the values before this instruction's own flag update
  assign take_s = buc_r | (bcf_r & carry_flag_r) | (bbf_r & borrow_flag_r);

  assign hs_s = instr_valid & ready_s;

  regfile_4x8 #(
    .REG_RST (REG_RST)
  ) u_rf (
    .clk (clk),
    .rst (rst),
    .ra0 (instr_r[RD_HI:RD_LO]),
    .ra1 (instr_r[RS_HI:RS_LO]),
    .rd0 (rf_rd0_s),
    .rd1 (rf_rd1_s),
    .we  (rf_we_s),
    .wa  (instr_r[RD_HI:RD_LO]),
    .wd  (res_r)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_FETCH;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_FETCH: begin
        if (hs_s) begin
          state_next_s = is_ldi(instr_in) ? ST_FETCH_IMM : ST_DECODE;
        end else begin
          state_next_s = ST_FETCH;
        end
      end
      ST_FETCH_IMM: begin
        if (hs_s) begin
          state_next_s = ST_DECODE;
        end else begin
          state_next_s = ST_FETCH_IMM;
        end
      end
      ST_DECODE:    state_next_s = ST_EXECUTE;
      ST_EXECUTE:   state_next_s = ST_WRITEBACK;
      ST_WRITEBACK: state_next_s = ST_FETCH;
      default:      state_next_s = ST_FETCH;
    endcase
  end

  // State-decoded outputs: handshake ready, busy, register write enable
  always_comb begin
    ready_s = 1'b0;
    busy_s  = 1'b1;
    rf_we_s = 1'b0;
    case (state_r)
      ST_FETCH: begin
        ready_s = 1'b1;
        busy_s  = 1'b0;
      end
      ST_FETCH_IMM: begin
        ready_s = 1'b1;
      end
      ST_WRITEBACK: begin
        // A taken branch or a toggle suppresses the register write
        rf_we_s = ~take_s & ~tog_r;
      end
      default: begin
        ready_s = 1'b0;
      end
    endcase
  end

  // Datapath: fetch latches, operand latches, ALU capture, commit
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r          <= '0;
      instr_r       <= 8'h00;
      imm_r         <= 8'h00;
      op0_r         <= 8'h00;
      op1_r         <= 8'h00;
      res_r         <= 8'h00;
      alu_carry_r   <= 1'b0;
      alu_borrow_r  <= 1'b0;
      bcf_r         <= 1'b0;
      bbf_r         <= 1'b0;
      buc_r         <= 1'b0;
      tog_r         <= 1'b0;
      carry_flag_r  <= 1'b0;
      borrow_flag_r <= 1'b0;
      toggle_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_FETCH: begin
          if (hs_s) begin
            instr_r <= instr_in;
            pc_r    <= pc_r + pc_one_s;
          end
        end
        ST_FETCH_IMM: begin
          if (hs_s) begin
            imm_r <= instr_in;
            pc_r  <= pc_r + pc_one_s;
          end
        end
        ST_DECODE: begin
          // MOV/branch sources its value from rs; LDI from the immediate
          if (is_ldi(instr_r)) begin
            op0_r <= imm_r;
          end else if (instr_r[OPC_HI:OPC_LO] == OP_MOV) begin
            op0_r <= rf_rd1_s;
          end else begin
            op0_r <= rf_rd0_s;
          end
          op1_r <= rf_rd1_s;
        end
        ST_EXECUTE: begin
          res_r        <= alu_dout;
          alu_carry_r  <= alu_carry;
          alu_borrow_r <= alu_borrow;
          bcf_r        <= alu_bcf;
          bbf_r        <= alu_bbf;
          buc_r        <= alu_buc;
          tog_r        <= alu_toggle;
        end
        ST_WRITEBACK: begin
          if (take_s) begin
            pc_r <= pc_target_s;
          end else if (tog_r) begin
            toggle_r <= ~toggle_r;
          end
          case (instr_r[OPC_HI:OPC_LO])
            OP_ADD:  carry_flag_r  <= alu_carry_r;
            OP_SUB:  borrow_flag_r <= alu_borrow_r;
            default: begin
            end
          endcase
        end
        default: begin
        end
      endcase
    end
  end

  // Ready is forced low while reset is asserted
  assign instr_ready = ready_s & ~rst;
  assign busy        = busy_s;
  assign pc          = pc_r;
  assign alu_opcode  = instr_r[OPC_HI:OPC_LO];
  assign alu_addrs   = instr_r[RD_HI:RS_LO];
  assign alu_d0      = op0_r;
  assign alu_d1      = op1_r;
  assign carry_flag  = carry_flag_r;
  assign borrow_flag = borrow_flag_r;
  assign toggle_out  = toggle_r;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed self-checking bench for cpu_sequencer. The bench plays the ALU:
// arithmetic results come from a small model, branch/toggle requests from
// bench-controlled variables that apply only to opcode 3.
module tb_cpu_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] instr_in;
  logic       instr_valid;
  logic       instr_ready;
  logic [7:0] pc;
  logic [1:0] alu_opcode;
  logic [3:0] alu_addrs;
  logic [7:0] alu_d0;
  logic [7:0] alu_d1;
  logic [7:0] alu_dout;
  logic       alu_carry;
  logic       alu_borrow;
  logic       alu_bcf;
  logic       alu_bbf;
  logic       alu_buc;
  logic       alu_toggle;
  logic       carry_flag;
  logic       borrow_flag;
  logic       toggle_out;
  logic       busy;

  logic req_bcf = 1'b0;
  logic req_bbf = 1'b0;
  logic req_buc = 1'b0;
  logic req_tog = 1'b0;

  int checks = 0;
  int errors = 0;

  int         lat;
  logic [7:0] cap_d0;
  logic [7:0] cap_d1;

  cpu_sequencer #(
    .PC_W    (8),
    .REG_RST (8'h00)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_in    (instr_in),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .pc          (pc),
    .alu_opcode  (alu_opcode),
    .alu_addrs   (alu_addrs),
    .alu_d0      (alu_d0),
    .alu_d1      (alu_d1),
    .alu_dout    (alu_dout),
    .alu_carry   (alu_carry),
    .alu_borrow  (alu_borrow),
    .alu_bcf     (alu_bcf),
    .alu_bbf     (alu_bbf),
    .alu_buc     (alu_buc),
    .alu_toggle  (alu_toggle),
    .carry_flag  (carry_flag),
    .borrow_flag (borrow_flag),
    .toggle_out  (toggle_out),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // ALU model
  logic [8:0] sum_s;
  logic [8:0] dif_s;
  always_comb begin
    sum_s      = {1'b0, alu_d0} + {1'b0, alu_d1};
    dif_s      = {1'b0, alu_d0} - {1'b0, alu_d1};
    alu_carry  = 1'b0;
    alu_borrow = 1'b0;
    case (alu_opcode)
      2'd0: begin alu_dout = sum_s[7:0]; alu_carry = sum_s[8]; end
      2'd1: begin alu_dout = dif_s[7:0]; alu_borrow = dif_s[8]; end
      2'd2: alu_dout = alu_d0 ^ alu_d1;
      default: alu_dout = alu_d0;
    endcase
    alu_bcf    = (alu_opcode == 2'd3) & req_bcf;
    alu_bbf    = (alu_opcode == 2'd3) & req_bbf;
    alu_buc    = (alu_opcode == 2'd3) & req_buc;
    alu_toggle = (alu_opcode == 2'd3) & req_tog;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a byte and hold it until the sequencer accepts it
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    instr_in    = b;
    instr_valid = 1'b1;
    while (!instr_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("handshake_ready", 32'(instr_ready), 32'd1);
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
  endtask

  // Count cycles from the handshake until the sequencer is ready again
  task automatic wait_done(output int cycles, output logic [7:0] d0, output logic [7:0] d1);
    cycles = 0;
    d0 = 8'h00;
    d1 = 8'h00;
    do begin
      @(negedge clk);
      cycles++;
      if (cycles == 2) begin
        d0 = alu_d0;
        d1 = alu_d1;
      end
    end while (!instr_ready && cycles < 20);
  endtask

  task automatic run_ldi(input logic [7:0] op, input logic [7:0] imm);
    send_byte(op);
    send_byte(imm);
    wait_done(lat, cap_d0, cap_d1);
  endtask

  task automatic run_op(input logic [7:0] op);
    send_byte(op);
    wait_done(lat, cap_d0, cap_d1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    rst         = 1'b1;
    instr_in    = 8'h00;
    instr_valid = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_ready", 32'(instr_ready), 32'd0);
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_carry", 32'(carry_flag), 32'd0);
    chk("rst_borrow", 32'(borrow_flag), 32'd0);
    chk("rst_toggle", 32'(toggle_out), 32'd0);
    chk("rst_d0", 32'(alu_d0), 32'd0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", 32'(instr_ready), 32'd1);

    // LDI r1,F0 ; LDI r2,20 ; ADD r1,r2
    run_ldi(8'hD3, 8'hF0);
    chk("ldi_r1", 32'(dut.u_rf.regs_r[1]), 32'hF0);
    run_ldi(8'hE3, 8'h20);
    run_op(8'h18);
    chk("add_latency", 32'(lat), 32'd4);
    chk("add_d0", 32'(cap_d0), 32'hF0);
    chk("add_d1", 32'(cap_d1), 32'h20);
    chk("add_r1", 32'(dut.u_rf.regs_r[1]), 32'h10);
    chk("add_carry", 32'(carry_flag), 32'd1);
    chk("add_borrow", 32'(borrow_flag), 32'd0);
    chk("add_pc", 32'(pc), 32'd5);

    // LDI r0,05 ; LDI r3,07 ; SUB r0,r3
    run_ldi(8'hC3, 8'h05);
    run_ldi(8'hF3, 8'h07);
    run_op(8'h4C);
    chk("sub_r0", 32'(dut.u_rf.regs_r[0]), 32'hFE);
    chk("sub_borrow", 32'(borrow_flag), 32'd1);
    chk("sub_carry_kept", 32'(carry_flag), 32'd1);
    chk("sub_pc", 32'(pc), 32'd10);

    // Branch on carry, taken: target = r2 = 0x40
    run_ldi(8'hE3, 8'h40);
    req_bcf = 1'b1;
    run_op(8'hE8);
    req_bcf = 1'b0;
    chk("bcf_taken_pc", 32'(pc), 32'h40);
    chk("bcf_r0", 32'(dut.u_rf.regs_r[0]), 32'hFE);
    chk("bcf_r1", 32'(dut.u_rf.regs_r[1]), 32'h10);
    chk("bcf_r2", 32'(dut.u_rf.regs_r[2]), 32'h40);
    chk("bcf_r3", 32'(dut.u_rf.regs_r[3]), 32'h07);

    // Clear carry with ADD r3,r3 (07+07), then branch not taken
    run_op(8'h3C);
    chk("add_nc_r3", 32'(dut.u_rf.regs_r[3]), 32'h0E);
    chk("add_nc_carry", 32'(carry_flag), 32'd0);
    req_bcf = 1'b1;
    run_op(8'hE8);
    req_bcf = 1'b0;
    chk("bcf_not_taken_pc", 32'(pc), 32'h42);
    chk("bcf_nt_r0", 32'(dut.u_rf.regs_r[0]), 32'hFE);

    // Stall in FETCH
    repeat (3) begin
      @(negedge clk);
      chk("stall_f_ready", 32'(instr_ready), 32'd1);
      chk("stall_f_busy", 32'(busy), 32'd0);
      chk("stall_f_pc", 32'(pc), 32'h42);
    end
    // Stall in FETCH_IMM
    send_byte(8'hD3);
    repeat (3) begin
      @(negedge clk);
      chk("stall_i_ready", 32'(instr_ready), 32'd1);
      chk("stall_i_busy", 32'(busy), 32'd1);
      chk("stall_i_pc", 32'(pc), 32'h43);
      chk("stall_i_r1", 32'(dut.u_rf.regs_r[1]), 32'h10);
    end
    send_byte(8'h55);
    wait_done(lat, cap_d0, cap_d1);
    chk("ldi_stall_r1", 32'(dut.u_rf.regs_r[1]), 32'h55);
    chk("ldi_stall_pc", 32'(pc), 32'h44);

    // Reset during EXECUTE of ADD r1,r2
    send_byte(8'h18);
    @(negedge clk);
    @(negedge clk);
    chk("exec_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_pc", 32'(pc), 32'd0);
    chk("abort_r1", 32'(dut.u_rf.regs_r[1]), 32'h00);
    chk("abort_carry", 32'(carry_flag), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_ready_in_rst", 32'(instr_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("abort_ready_after", 32'(instr_ready), 32'd1);

    // Toggle twice
    req_tog = 1'b1;
    run_op(8'hC0);
    chk("toggle_1", 32'(toggle_out), 32'd1);
    chk("toggle_1_r0", 32'(dut.u_rf.regs_r[0]), 32'h00);
    run_op(8'hC0);
    chk("toggle_2", 32'(toggle_out), 32'd0);
    req_tog = 1'b0;
    chk("toggle_pc", 32'(pc), 32'd2);

    // Branch + toggle together to 0xFF: branch wins
    run_ldi(8'hE3, 8'hFF);
    req_buc = 1'b1;
    req_tog = 1'b1;
    run_op(8'hE8);
    req_buc = 1'b0;
    req_tog = 1'b0;
    chk("buc_pc", 32'(pc), 32'hFF);
    chk("buc_toggle_dropped", 32'(toggle_out), 32'd0);

    // Fetch at 0xFF wraps pc to 0x00
    send_byte(8'hBC);
    chk("wrap_pc", 32'(pc), 32'h00);
    wait_done(lat, cap_d0, cap_d1);
    chk("xor_r3", 32'(dut.u_rf.regs_r[3]), 32'h00);
    chk("xor_latency", 32'(lat), 32'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
